motor_cmd_sequencer: RTL and testbench

//  Sequences the two stepper MotorDriver channels from the ControlLoop's signed target speeds.

---
 rtl/motor_seq_pkg.sv | 19 +
 rtl/motor_ramp_channel.sv | 92 +++++++++
 rtl/motor_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_seq_pkg.sv
// Shared types and default constants for the two-channel stepper command sequencer.
package motor_seq_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAKE     = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_SPEED_W       = 10;
    localparam int unsigned DEF_MAX_SPEED     = 500;
    localparam int unsigned DEF_RAMP_DIV      = 100000;
    localparam int unsigned DEF_RAMP_STEP     = 4;
    localparam int unsigned DEF_DIR_SETUP_CYC = 200;
    localparam int unsigned DEF_WAKE_CYC      = 100000;
    localparam logic [2:0]  DEF_MS_CFG        = 3'b000;

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: clamps the target, slew-limits the speed and runs the
// ramp-to-zero / direction flip / setup-hold sequence on reversals.
module motor_ramp_channel
    import motor_seq_pkg::*;
#(
    parameter int unsigned SPEED_W       = DEF_SPEED_W,
    parameter int unsigned MAX_SPEED     = DEF_MAX_SPEED,
    parameter int unsigned RAMP_STEP     = DEF_RAMP_STEP,
    parameter int unsigned DIR_SETUP_CYC = DEF_DIR_SETUP_CYC
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      enable,
    input  logic                      force_zero,
    input  logic signed [SPEED_W-1:0] tgt,
    output logic        [SPEED_W-1:0] speed,
    output logic                      dir,
    output logic                      idle
);

    localparam int unsigned EW     = SPEED_W + 1;
    localparam int unsigned HOLD_W = $clog2(DIR_SETUP_CYC + 2);
    localparam logic signed [EW-1:0] MAX_S = EW'(MAX_SPEED);
    localparam logic signed [EW-1:0] MIN_S = -MAX_S;

    logic        [SPEED_W-1:0] speed_q, speed_d;
    logic                      dir_q, dir_d;
    logic        [HOLD_W-1:0]  hold_q, hold_d;
    logic                      idle_q, idle_d;

    logic signed [EW-1:0] tgt_ext, tgt_cl;
    logic        [EW-1:0] tmag, spd_ext, up, dn;
    logic                 tgt_neg, tgt_zero, same_dir;

    // Clamp, then work on magnitudes one bit wider than the speed so nothing wraps.
    always_comb begin
        tgt_ext = {tgt[SPEED_W-1], tgt};
        if (force_zero)           tgt_cl = '0;
        else if (tgt_ext > MAX_S) tgt_cl = MAX_S;
        else if (tgt_ext < MIN_S) tgt_cl = MIN_S;
        else                      tgt_cl = tgt_ext;

        tgt_neg  = tgt_cl[EW-1];
        tgt_zero = (tgt_cl == '0);
        tmag     = tgt_neg ? EW'(-tgt_cl) : EW'(tgt_cl);
        same_dir = tgt_zero || (tgt_neg != dir_q);
        spd_ext  = {1'b0, speed_q};
        up       = spd_ext + EW'(RAMP_STEP);
        dn       = (spd_ext > EW'(RAMP_STEP)) ? spd_ext - EW'(RAMP_STEP) : '0;

        speed_d = speed_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        if (!enable) begin
            speed_d = '0;
            hold_d  = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (tick) begin
            if (same_dir) begin
                if (spd_ext < tmag) speed_d = SPEED_W'((up > tmag) ? tmag : up);
                else                speed_d = SPEED_W'((dn < tmag) ? tmag : dn);
            end else if (speed_q != '0) begin
                speed_d = SPEED_W'(dn);
            end else begin
                dir_d  = ~dir_q;
                hold_d = HOLD_W'(DIR_SETUP_CYC);
            end
        end
        idle_d = (speed_d == '0) && (hold_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            speed_q <= '0;
            dir_q   <= 1'b1;
            hold_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            speed_q <= speed_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
        end
    end

    assign speed = speed_q;
    assign dir   = dir_q;
    assign idle  = idle_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Drives both MotorDriver channels from signed ControlLoop targets and owns the
// shared enable/microstep pins: wake delay, graceful stop and estop kill.
module motor_cmd_sequencer
    import motor_seq_pkg::*;
#(
    parameter int unsigned SPEED_W       = DEF_SPEED_W,
    parameter int unsigned MAX_SPEED     = DEF_MAX_SPEED,
    parameter int unsigned RAMP_DIV      = DEF_RAMP_DIV,
    parameter int unsigned RAMP_STEP     = DEF_RAMP_STEP,
    parameter int unsigned DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
    parameter int unsigned WAKE_CYC      = DEF_WAKE_CYC,
    parameter logic [2:0]  MS_CFG        = DEF_MS_CFG
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      estop,
    input  logic signed [SPEED_W-1:0] target_left,
    input  logic signed [SPEED_W-1:0] target_right,
    input  logic                      target_valid,
    output logic        [SPEED_W-1:0] left_speed,
    output logic                      left_dir,
    output logic        [SPEED_W-1:0] right_speed,
    output logic                      right_dir,
    output logic                      run_en,
    output logic                      en_n,
    output logic        [2:0]         ms,
    output logic                      fault,
    output seq_state_t                state
);

    localparam int unsigned PRESC_W = $clog2(RAMP_DIV + 1);
    localparam int unsigned WAKE_W  = $clog2(WAKE_CYC + 1);

    seq_state_t                state_q;
    logic        [PRESC_W-1:0] presc_q;
    logic        [WAKE_W-1:0]  wake_q;
    logic                      run_en_q, en_n_q, fault_q;
    logic        [2:0]         ms_q;
    logic signed [SPEED_W-1:0] tgt_l_q, tgt_r_q;
    logic                      active_c, tick_c, ch_en_c, stop_c, idle_l, idle_r;

    assign active_c = (state_q == RUN) || (state_q == STOPPING);
    assign tick_c   = active_c && (presc_q == PRESC_W'(RAMP_DIV - 1));
    assign ch_en_c  = active_c && !estop;
    assign stop_c   = (state_q == STOPPING);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tgt_l_q <= '0;
            tgt_r_q <= '0;
        end else if (target_valid) begin
            tgt_l_q <= target_left;
            tgt_r_q <= target_right;
        end
    end

    // Sequencer FSM with prescaler, wake counter and fault latch; estop overrides everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DISABLED;
            presc_q  <= '0;
            wake_q   <= '0;
            run_en_q <= 1'b0;
            en_n_q   <= 1'b1;
            ms_q     <= 3'b000;
            fault_q  <= 1'b0;
        end else if (estop) begin
            state_q  <= DISABLED;
            presc_q  <= '0;
            wake_q   <= '0;
            run_en_q <= 1'b0;
            en_n_q   <= 1'b1;
            ms_q     <= 3'b000;
            fault_q  <= 1'b1;
        end else begin
            if (fault_q && !arm) fault_q <= 1'b0;
            if (active_c) presc_q <= tick_c ? '0 : presc_q + 1'b1;
            case (state_q)
                DISABLED: begin
                    if (arm && !fault_q) begin
                        state_q <= WAKE;
                        wake_q  <= '0;
                        en_n_q  <= 1'b0;
                        ms_q    <= MS_CFG;
                    end
                end
                WAKE: begin
                    if (!arm) begin
                        state_q <= DISABLED;
                        en_n_q  <= 1'b1;
                        ms_q    <= 3'b000;
                    end else if (wake_q == WAKE_W'(WAKE_CYC - 1)) begin
                        state_q  <= RUN;
                        presc_q  <= '0;
                        run_en_q <= 1'b1;
                    end else begin
                        wake_q <= wake_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!arm) state_q <= STOPPING;
                end
                STOPPING: begin
                    if (arm) begin
                        state_q  <= WAKE;
                        wake_q   <= '0;
                        run_en_q <= 1'b0;
                    end else if (idle_l && idle_r) begin
                        state_q  <= DISABLED;
                        run_en_q <= 1'b0;
                        en_n_q   <= 1'b1;
                        ms_q     <= 3'b000;
                    end
                end
                default: state_q <= DISABLED;
            endcase
        end
    end

    motor_ramp_channel #(
        .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED),
        .RAMP_STEP(RAMP_STEP), .DIR_SETUP_CYC(DIR_SETUP_CYC)
    ) u_left (
        .clock(clock), .reset(reset), .tick(tick_c), .enable(ch_en_c),
        .force_zero(stop_c), .tgt(tgt_l_q),
        .speed(left_speed), .dir(left_dir), .idle(idle_l)
    );

    motor_ramp_channel #(
        .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED),
        .RAMP_STEP(RAMP_STEP), .DIR_SETUP_CYC(DIR_SETUP_CYC)
    ) u_right (
        .clock(clock), .reset(reset), .tick(tick_c), .enable(ch_en_c),
        .force_zero(stop_c), .tgt(tgt_r_q),
        .speed(right_speed), .dir(right_dir), .idle(idle_r)
    );

    assign state  = state_q;
    assign run_en = run_en_q;
    assign en_n   = en_n_q;
    assign ms     = ms_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer with short ramp/wake constants.
module tb_motor_cmd_sequencer;
    import motor_seq_pkg::*;

    localparam int unsigned SW = 10;

    logic                 clock = 1'b0;
    logic                 reset, arm, estop, target_valid;
    logic signed [SW-1:0] target_left, target_right;
    logic        [SW-1:0] left_speed, right_speed;
    logic                 left_dir, right_dir, run_en, en_n, fault;
    logic        [2:0]    ms;
    seq_state_t           state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    motor_cmd_sequencer #(
        .SPEED_W(SW), .MAX_SPEED(500), .RAMP_DIV(4), .RAMP_STEP(4),
        .DIR_SETUP_CYC(3), .WAKE_CYC(8), .MS_CFG(3'b101)
    ) dut (
        .clock(clock), .reset(reset), .arm(arm), .estop(estop),
        .target_left(target_left), .target_right(target_right),
        .target_valid(target_valid),
        .left_speed(left_speed), .left_dir(left_dir),
        .right_speed(right_speed), .right_dir(right_dir),
        .run_en(run_en), .en_n(en_n), .ms(ms), .fault(fault), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input int l, input int r);
        target_left  = SW'(l);
        target_right = SW'(r);
        target_valid = 1'b1;
        step(1);
        target_valid = 1'b0;
    endtask

    task automatic chk_left(input string tag, input int spd, input int dir);
        check({tag, "_spd"}, 32'(left_speed), 32'(spd));
        check({tag, "_dir"}, 32'(left_dir), 32'(dir));
    endtask

    // Bounded wait for both channels to reach the given speed/dir, then compare.
    task automatic wait_speeds(input string tag, input int l, input int ld,
                               input int r, input int rd, input int budget);
        logic [21:0] exp;
        int n;
        exp = {ld[0], SW'(l), rd[0], SW'(r)};
        n = 0;
        while ({left_dir, left_speed, right_dir, right_speed} !== exp && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'({left_dir, left_speed, right_dir, right_speed}), 32'(exp));
    endtask

    task automatic wait_state(input string tag, input seq_state_t s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; estop = 1'b0; target_valid = 1'b0;
        target_left = '0; target_right = '0;
        step(2);
        check("rst_lspd", 32'(left_speed), 32'd0);
        check("rst_rspd", 32'(right_speed), 32'd0);
        check("rst_ldir", 32'(left_dir), 32'd1);
        check("rst_rdir", 32'(right_dir), 32'd1);
        check("rst_run",  32'(run_en), 32'd0);
        check("rst_en_n", 32'(en_n), 32'd1);
        check("rst_ms",   32'(ms), 32'd0);
        check("rst_flt",  32'(fault), 32'd0);
        check("rst_st",   32'(state), 32'(DISABLED));
        reset = 1'b0;
        step(1);

        // wake sequence
        arm = 1'b1;
        step(1);
        check("wake_en_n", 32'(en_n), 32'd0);
        check("wake_st",   32'(state), 32'(WAKE));
        check("wake_ms",   32'(ms), 32'd5);
        step(7);
        check("wake_run0", 32'(run_en), 32'd0);
        step(1);
        check("run_en",    32'(run_en), 32'd1);
        check("run_st",    32'(state), 32'(RUN));

        // ramp up to +20, one step per 4 clocks
        strobe(20, 0);
        step(2);
        chk_left("ramp_pre", 0, 1);
        step(1);
        chk_left("ramp4", 4, 1);
        for (int k = 2; k <= 5; k++) begin
            step(4);
            chk_left("ramp", 4 * k, 1);
        end
        step(4);
        chk_left("ramp_hold", 20, 1);
        check("ramp_right", 32'(right_speed), 32'd0);

        // back down to +8, then reverse to -8
        strobe(8, 0);
        step(3);  chk_left("down16", 16, 1);
        step(4);  chk_left("down12", 12, 1);
        step(4);  chk_left("down8", 8, 1);
        strobe(-8, 0);
        step(3);  chk_left("rev4", 4, 1);
        step(4);  chk_left("rev0", 0, 1);
        step(4);  chk_left("flip", 0, 0);
        step(3);  chk_left("setup", 0, 0);
        step(1);  chk_left("out4", 4, 0);
        step(4);  chk_left("out8", 8, 0);

        // clamp: right lands exactly on 10, left clamps to 500
        strobe(511, 10);
        step(3);  check("r4",  32'(right_speed), 32'd4);
        step(4);  check("r8",  32'(right_speed), 32'd8);
        step(4);  check("r10", 32'(right_speed), 32'd10);
        step(4);  check("r10h", 32'(right_speed), 32'd10);
        wait_speeds("clamp_pos", 500, 1, 10, 1, 1200);
        step(8);
        chk_left("clamp_pos_hold", 500, 1);
        strobe(-512, 10);
        wait_speeds("clamp_neg", 500, 0, 10, 1, 1500);
        target_left  = SW'(0);
        target_right = SW'(-100);
        step(20);
        wait_speeds("no_valid", 500, 0, 10, 1, 0);

        // estop mid-ramp
        strobe(100, 10);
        step(10);
        estop = 1'b1;
        step(1);
        check("es_lspd", 32'(left_speed), 32'd0);
        check("es_rspd", 32'(right_speed), 32'd0);
        check("es_run",  32'(run_en), 32'd0);
        check("es_en_n", 32'(en_n), 32'd1);
        check("es_flt",  32'(fault), 32'd1);
        check("es_st",   32'(state), 32'(DISABLED));
        step(3);
        estop = 1'b0;
        step(3);
        check("es_rearm_st",  32'(state), 32'(DISABLED));
        check("es_rearm_flt", 32'(fault), 32'd1);
        check("es_rearm_en",  32'(en_n), 32'd1);
        arm = 1'b0;
        step(1);
        check("es_clear", 32'(fault), 32'd0);

        // graceful stop from 20/20
        arm = 1'b1;
        step(9);
        check("rearm_st", 32'(state), 32'(RUN));
        strobe(20, 20);
        wait_speeds("both20", 20, 1, 20, 1, 200);
        arm = 1'b0;
        step(1);
        check("stop_st", 32'(state), 32'(STOPPING));
        for (int v = 16; v >= 0; v -= 4) wait_speeds("stop_ramp", v, 1, v, 1, 6);
        wait_state("stop_done", DISABLED, 4);
        check("stop_en_n", 32'(en_n), 32'd1);
        check("stop_run",  32'(run_en), 32'd0);

        // arm returns during STOPPING
        arm = 1'b1;
        step(9);
        check("run2_st", 32'(state), 32'(RUN));
        wait_speeds("run2", 20, 1, 20, 1, 200);
        arm = 1'b0;
        step(1);
        check("stop2_st", 32'(state), 32'(STOPPING));
        step(2);
        arm = 1'b1;
        step(1);
        check("rewake_st",   32'(state), 32'(WAKE));
        check("rewake_en_n", 32'(en_n), 32'd0);
        check("rewake_run",  32'(run_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
